// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs -- definitions shared by the decode-stage files.
//
// Contents:
//   - Bit positions of the MIPS-style instruction fields.
//   - NOP_INSTR, REG_ZERO and OP_LW constants.
//   - if_id_t, the contents of the IF/ID pipeline register.
// -----------------------------------------------------------------------------
package cpu_defs;

    // Instruction field bit positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [5:0]  OP_LW     = 6'b100011;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file -- general-purpose register array.
//
// The array has two asynchronous read ports and one synchronous write port.
// A synchronous reset clears every register. Register $0 always reads zero,
// and writes to it are dropped.
//
// Configuration macro:
//   ID_WRITE_BYPASS_EN
//     Defined:   a read of the register being written this cycle returns
//                write_data (write-through).
//     Undefined: the read returns the old contents until the next cycle.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high; clears all registers
//   read_addr1   in   5-bit read address, port 1
//   read_addr2   in   5-bit read address, port 2
//   write_en     in   write enable
//   write_addr   in   5-bit write address
//   write_data   in   DATA_W write data
//   read_data1   out  DATA_W data for read_addr1
//   read_data2   out  DATA_W data for read_addr2
// -----------------------------------------------------------------------------
module register_file
    import cpu_defs::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        read_addr1,
    input  logic [4:0]        read_addr2,
    input  logic              write_en,
    input  logic [4:0]        write_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // NOTE: the whole array is cleared on reset because software expects every
    // GPR to start at zero. This rules out block-RAM inference, which is
    // acceptable for a 32-entry array.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en && (write_addr != REG_ZERO)) begin
            regs[write_addr] <= write_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
        logic [DATA_W-1:0] data;
        if (addr == REG_ZERO) begin
            data = '0;
`ifdef ID_WRITE_BYPASS_EN
        end else if (write_en && (write_addr == addr)) begin
            data = write_data;
`endif
        end else begin
            data = regs[addr];
        end
        return data;
    endfunction

    always_comb begin
        read_data1 = read_port(read_addr1);
        read_data2 = read_port(read_addr2);
    end

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- instruction-decode pipeline stage.
//
// This stage contains three blocks:
//   - The IF/ID register, with update priority Reset > Flush > stall > load.
//   - Combinational field decode and sign extension.
//   - Load-use hazard detection.
// It also instantiates register_file.
//
// Configuration macro:
//   ID_WRITE_BYPASS_EN
//     Enables same-cycle write-through in register_file.
//
// Ports:
//   Clk             in   rising-edge clock
//   Reset           in   synchronous, active-high
//   IF_Instruction  in   instruction word from fetch
//   IF_PCPlus4      in   PC+4 from fetch
//   Flush           in   taken branch/jump; squash IF/ID
//   EX_MemRead      in   the instruction in EX is a load
//   EX_Rt           in   destination register of that load
//   WB_RegWrite     in   write-back enable
//   WB_WriteReg     in   write-back register address
//   WB_WriteData    in   write-back data
//   HazardStall     out  to fetch: hold the PC and IF/ID
//   ID_Valid        out  EX may consume this cycle's outputs
//   ID_PCPlus4      out  latched PC+4
//   ID_ReadData1/2  out  GPR[rs] and GPR[rt]
//   ID_ImmExt       out  sign-extended instr[15:0]
//   ID_Opcode, ID_Funct, ID_Rs, ID_Rt, ID_Rd, ID_Shamt
//                   out  decoded instruction fields
// -----------------------------------------------------------------------------
module id_stage
    import cpu_defs::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [31:0]       IF_Instruction,
    input  logic [31:0]       IF_PCPlus4,
    input  logic              Flush,
    input  logic              EX_MemRead,
    input  logic [4:0]        EX_Rt,
    input  logic              WB_RegWrite,
    input  logic [4:0]        WB_WriteReg,
    input  logic [DATA_W-1:0] WB_WriteData,
    output logic              HazardStall,
    output logic              ID_Valid,
    output logic [31:0]       ID_PCPlus4,
    output logic [DATA_W-1:0] ID_ReadData1,
    output logic [DATA_W-1:0] ID_ReadData2,
    output logic [DATA_W-1:0] ID_ImmExt,
    output logic [5:0]        ID_Opcode,
    output logic [5:0]        ID_Funct,
    output logic [4:0]        ID_Rs,
    output logic [4:0]        ID_Rt,
    output logic [4:0]        ID_Rd,
    output logic [4:0]        ID_Shamt
);

    if_id_t     if_id;
    logic [4:0] rs;
    logic [4:0] rt;

    // IF/ID register. A flush holds the PC+4 field: once valid is cleared,
    // the value has no meaning to EX.
    // NOTE: all sequential state uses non-blocking assignments. Every flop
    // then samples the pre-edge values, so the evaluation order of the
    // always blocks cannot affect the result.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            if_id.instr    <= NOP_INSTR;
            if_id.pc_plus4 <= '0;
            if_id.valid    <= 1'b0;
        end else if (Flush) begin
            if_id.instr    <= NOP_INSTR;
            if_id.valid    <= 1'b0;
        end else if (!HazardStall) begin
            if_id.instr    <= IF_Instruction;
            if_id.pc_plus4 <= IF_PCPlus4;
            if_id.valid    <= 1'b1;
        end
    end

    assign rs = if_id.instr[RS_MSB:RS_LSB];
    assign rt = if_id.instr[RT_MSB:RT_LSB];

    // A load in EX whose destination is one of our sources forces one bubble.
    // $0 is never a real dependency. A NOP has rs = rt = 0, so it never stalls.
    // NOTE: every output of a combinational block is given a default first.
    // Otherwise, a path that skips an assignment would infer a latch.
    always_comb begin
        HazardStall = 1'b0;
        if (if_id.valid && EX_MemRead && (EX_Rt != REG_ZERO) &&
            ((EX_Rt == rs) || (EX_Rt == rt))) begin
            HazardStall = 1'b1;
        end
    end

    assign ID_Valid   = if_id.valid & ~HazardStall;
    assign ID_PCPlus4 = if_id.pc_plus4;
    assign ID_Opcode  = if_id.instr[OPCODE_MSB:OPCODE_LSB];
    assign ID_Funct   = if_id.instr[FUNCT_MSB:FUNCT_LSB];
    assign ID_Rs      = rs;
    assign ID_Rt      = rt;
    assign ID_Rd      = if_id.instr[RD_MSB:RD_LSB];
    assign ID_Shamt   = if_id.instr[SHAMT_MSB:SHAMT_LSB];
    assign ID_ImmExt  = {{(DATA_W-16){if_id.instr[IMM_MSB]}},
                         if_id.instr[IMM_MSB:IMM_LSB]};

    register_file #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) u_register_file (
        .clk        (Clk),
        .reset      (Reset),
        .read_addr1 (rs),
        .read_addr2 (rt),
        .write_en   (WB_RegWrite),
        .write_addr (WB_WriteReg),
        .write_data (WB_WriteData),
        .read_data1 (ID_ReadData1),
        .read_data2 (ID_ReadData2)
    );

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage -- self-checking bench for id_stage.
//
// The reference model holds three items:
//   - The IF/ID contents.
//   - A plain array of register values.
//   - The decode rules, stated directly as arithmetic.
// On every falling edge, the DUT outputs are compared with the model.
// Directed steps add literal expectations that pin the model itself.
//
// The bench also tracks ID_WRITE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_id_stage;
    import cpu_defs::*;

    logic        Clk;
    logic        Reset;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PCPlus4;
    logic        Flush;
    logic        EX_MemRead;
    logic [4:0]  EX_Rt;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteReg;
    logic [31:0] WB_WriteData;
    logic        HazardStall;
    logic        ID_Valid;
    logic [31:0] ID_PCPlus4;
    logic [31:0] ID_ReadData1;
    logic [31:0] ID_ReadData2;
    logic [31:0] ID_ImmExt;
    logic [5:0]  ID_Opcode;
    logic [5:0]  ID_Funct;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic [4:0]  ID_Rd;
    logic [4:0]  ID_Shamt;

    int tests = 0;
    int fails = 0;

    id_stage dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .IF_Instruction (IF_Instruction),
        .IF_PCPlus4     (IF_PCPlus4),
        .Flush          (Flush),
        .EX_MemRead     (EX_MemRead),
        .EX_Rt          (EX_Rt),
        .WB_RegWrite    (WB_RegWrite),
        .WB_WriteReg    (WB_WriteReg),
        .WB_WriteData   (WB_WriteData),
        .HazardStall    (HazardStall),
        .ID_Valid       (ID_Valid),
        .ID_PCPlus4     (ID_PCPlus4),
        .ID_ReadData1   (ID_ReadData1),
        .ID_ReadData2   (ID_ReadData2),
        .ID_ImmExt      (ID_ImmExt),
        .ID_Opcode      (ID_Opcode),
        .ID_Funct       (ID_Funct),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_Rd          (ID_Rd),
        .ID_Shamt       (ID_Shamt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_valid;
    bit          m_known = 0;

    function automatic logic model_stall();
        logic [4:0] s;
        logic [4:0] t;
        s = m_instr[25:21];
        t = m_instr[20:16];
        return m_valid && EX_MemRead && (EX_Rt != 5'd0) && (EX_Rt == s || EX_Rt == t);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef ID_WRITE_BYPASS_EN
        if (WB_RegWrite && WB_WriteReg == a) return WB_WriteData;
`endif
        return m_regs[a];
    endfunction

    always @(posedge Clk) begin
        logic stall_now;
        stall_now = model_stall();
        if (Reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_instr = 32'h0;
            m_pc    = 32'h0;
            m_valid = 1'b0;
            m_known = 1;
        end else begin
            if (WB_RegWrite && WB_WriteReg != 5'd0) m_regs[WB_WriteReg] = WB_WriteData;
            if (Flush) begin
                m_instr = 32'h0;
                m_valid = 1'b0;
            end else if (!stall_now) begin
                m_instr = IF_Instruction;
                m_pc    = IF_PCPlus4;
                m_valid = 1'b1;
            end
        end
    end

    // Compare process: on every cycle after the first reset edge
    always @(negedge Clk) begin
        if (m_known) begin
            check("stall",   HazardStall,  model_stall());
            check("valid",   ID_Valid,     m_valid && !model_stall());
            check("pc",      ID_PCPlus4,   m_pc);
            check("opcode",  ID_Opcode,    m_instr[31:26]);
            check("funct",   ID_Funct,     m_instr[5:0]);
            check("rs",      ID_Rs,        m_instr[25:21]);
            check("rt",      ID_Rt,        m_instr[20:16]);
            check("rd",      ID_Rd,        m_instr[15:11]);
            check("shamt",   ID_Shamt,     m_instr[10:6]);
            check("imm",     ID_ImmExt,    32'(signed'(m_instr[15:0])));
            check("rdata1",  ID_ReadData1, model_read(m_instr[25:21]));
            check("rdata2",  ID_ReadData2, model_read(m_instr[20:16]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [31:0] instr;
        Reset = 1'b1;
        IF_Instruction = 32'h8C220004;
        IF_PCPlus4 = 32'h4;
        Flush = 1'b0;
        EX_MemRead = 1'b0;
        EX_Rt = 5'd0;
        WB_RegWrite = 1'b0;
        WB_WriteReg = 5'd0;
        WB_WriteData = 32'h0;

        // 1. Reset for two cycles, then the first load
        tick();
        tick();
        check("t1_valid_rst", ID_Valid, 1'b0);
        check("t1_stall_rst", HazardStall, 1'b0);
        check("t1_opcode_rst", ID_Opcode, 6'h0);
        check("t1_imm_rst", ID_ImmExt, 32'h0);
        check("t1_pc_rst", ID_PCPlus4, 32'h0);
        check("t1_rd1_rst", ID_ReadData1, 32'h0);
        Reset = 1'b0;
        tick();
        check("t1_opcode", ID_Opcode, 6'h23);
        check("t1_is_lw", ID_Opcode, OP_LW);
        check("t1_rs", ID_Rs, 5'd1);
        check("t1_rt", ID_Rt, 5'd2);
        check("t1_imm", ID_ImmExt, 32'h4);
        check("t1_valid", ID_Valid, 1'b1);
        check("t1_pc", ID_PCPlus4, 32'h4);

        // 2. Write $5, then read it on both ports; $0 writes are ignored
        WB_RegWrite = 1'b1; WB_WriteReg = 5'd5; WB_WriteData = 32'hDEADBEEF;
        IF_Instruction = 32'h00A53020; IF_PCPlus4 = 32'h8;
        tick();
        check("t2_rd1", ID_ReadData1, 32'hDEADBEEF);
        check("t2_rd2", ID_ReadData2, 32'hDEADBEEF);
        check("t2_rd", ID_Rd, 5'd6);
        check("t2_funct", ID_Funct, 6'h20);
        WB_WriteReg = 5'd0; WB_WriteData = 32'h1234;
        IF_Instruction = 32'h00001020; IF_PCPlus4 = 32'hC;
        tick();
        check("t2_zero_rd1", ID_ReadData1, 32'h0);
        WB_RegWrite = 1'b0;
        tick();
        check("t2_zero_rd2", ID_ReadData2, 32'h0);

        // 3. Load-use stall for one cycle
        IF_Instruction = 32'h00A53020; IF_PCPlus4 = 32'h10;
        tick();
        EX_MemRead = 1'b1; EX_Rt = 5'd5;
        IF_Instruction = 32'h01084020; IF_PCPlus4 = 32'h14;
        #1;
        check("t3_stall", HazardStall, 1'b1);
        check("t3_valid", ID_Valid, 1'b0);
        tick();
        EX_MemRead = 1'b0;
        #1;
        check("t3_stall_drop", HazardStall, 1'b0);
        check("t3_valid_back", ID_Valid, 1'b1);
        check("t3_rs_held", ID_Rs, 5'd5);
        check("t3_pc_held", ID_PCPlus4, 32'h10);
        tick();
        check("t3_next_rs", ID_Rs, 5'd8);

        // 4. Flush together with a stall: the flush wins
        EX_MemRead = 1'b1; EX_Rt = 5'd8; Flush = 1'b1;
        IF_Instruction = 32'h00000000; IF_PCPlus4 = 32'h18;
        #1;
        check("t4_stall", HazardStall, 1'b1);
        tick();
        check("t4_valid", ID_Valid, 1'b0);
        check("t4_stall_drop", HazardStall, 1'b0);
        check("t4_rs_nop", ID_Rs, 5'd0);
        Flush = 1'b0; EX_MemRead = 1'b0;

        // 5. Same-cycle write-back to a register being decoded
        WB_RegWrite = 1'b1; WB_WriteReg = 5'd7; WB_WriteData = 32'h55;
        IF_Instruction = 32'h00E00020; IF_PCPlus4 = 32'h1C;
        tick();
        check("t5_old", ID_ReadData1, 32'h55);
        WB_WriteData = 32'h77;
        #1;
`ifdef ID_WRITE_BYPASS_EN
        check("t5_same_cycle", ID_ReadData1, 32'h77);
`else
        check("t5_same_cycle", ID_ReadData1, 32'h55);
`endif
        tick();
        WB_RegWrite = 1'b0;
        #1;
        check("t5_next_cycle", ID_ReadData1, 32'h77);

        // 6. Negative immediate, then reset with a pending stall
        IF_Instruction = 32'h20018001; IF_PCPlus4 = 32'h20;
        tick();
        check("t6_imm_neg", ID_ImmExt, 32'hFFFF8001);
        check("t6_opcode", ID_Opcode, 6'h08);
        EX_MemRead = 1'b1; EX_Rt = 5'd1;
        #1;
        check("t6_stall_pending", HazardStall, 1'b1);
        Reset = 1'b1;
        WB_RegWrite = 1'b1; WB_WriteReg = 5'd3; WB_WriteData = 32'h99;
        tick();
        check("t6_rst_valid", ID_Valid, 1'b0);
        check("t6_rst_stall", HazardStall, 1'b0);
        check("t6_rst_pc", ID_PCPlus4, 32'h0);
        check("t6_rst_imm", ID_ImmExt, 32'h0);
        check("t6_rst_opcode", ID_Opcode, 6'h0);
        Reset = 1'b0; EX_MemRead = 1'b0; WB_RegWrite = 1'b0;
        IF_Instruction = 32'h00A31020; IF_PCPlus4 = 32'h24;
        tick();
        check("t6_gpr5_cleared", ID_ReadData1, 32'h0);
        check("t6_gpr3_no_write", ID_ReadData2, 32'h0);

        // Mixed traffic, checked by the compare process
        for (int i = 0; i < 40; i++) begin
            instr = $urandom;
            instr[25:21] = 5'($urandom_range(0, 7));
            instr[20:16] = 5'($urandom_range(0, 7));
            IF_Instruction = instr;
            IF_PCPlus4 = IF_PCPlus4 + 32'd4;
            Flush = ($urandom_range(0, 7) == 0);
            EX_MemRead = ($urandom_range(0, 2) == 0);
            EX_Rt = 5'($urandom_range(0, 7));
            WB_RegWrite = ($urandom_range(0, 1) == 1);
            WB_WriteReg = 5'($urandom_range(0, 7));
            WB_WriteData = $urandom;
            tick();
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage directly downstream of the instruction fetch unit.
- Latches the fetched Instruction/PC+4 into an IF/ID pipeline register, then decodes fields.
- Reads a 32x32 register file that the write-back stage updates.
- Detects load-use hazards and returns a stall to fetch; presents decoded operands to EX.
- On the board build, the low halves of ID_ReadData1 and ID_PCPlus4 may drive the two-number 7-segment display for bring-up.

Parameters:
- NUM_REGS, 32, register-file depth (address width fixed at 5).
- DATA_W, 32, datapath width.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- IF_Instruction  in  32  instruction word from fetch.
- IF_PCPlus4  in  32  PC+4 from fetch.
- Flush  in  1  branch/jump taken; squash the IF/ID contents.
- EX_MemRead  in  1  instruction currently in EX is a load.
- EX_Rt  in  5  destination register of that load.
- WB_RegWrite  in  1  write-back enable.
- WB_WriteReg  in  5  write-back register address.
- WB_WriteData  in  32  write-back data.
- HazardStall  out  1  to fetch: hold PC and IF/ID.
- ID_Valid  out  1  EX may consume this cycle's outputs.
- ID_PCPlus4  out  32  latched PC+4.
- ID_ReadData1  out  32  GPR[rs].
- ID_ReadData2  out  32  GPR[rt].
- ID_ImmExt  out  32  sign-extended instr[15:0].
- ID_Opcode  out  6  instr[31:26].
- ID_Funct  out  6  instr[5:0].
- ID_Rs, ID_Rt, ID_Rd  out  5 each  instr[25:21], [20:16], [15:11].
- ID_Shamt  out  5  instr[10:6].

Behaviour:
- Reset (synchronous, takes effect on the Clk edge while Reset=1):
  - IF/ID instruction = 32'h0 (NOP), PC+4 = 0, valid bit = 0, all GPRs = 0.
  - Hence ID_Valid=0, HazardStall=0, and all data outputs = 0 on the first cycle after reset.
  - Reset mid-operation overrides Flush, stall and WB write in the same cycle.
- IF/ID register priority per edge: Reset > Flush > HazardStall > load.
  - Flush: instruction=0, valid=0.
  - HazardStall: hold all IF/ID contents.
  - Otherwise: capture IF_Instruction and IF_PCPlus4, valid=1.
- All decode and ID_* outputs are combinational from the IF/ID register and the register file. Latency from IF inputs to ID outputs is exactly 1 cycle.
- Register-file reads:
  - Asynchronous.
  - Address 0 always reads 0.
- Register-file writes:
  - Occur on the rising edge when WB_RegWrite=1 and WB_WriteReg!=0.
  - Writes to $0 are ignored.
- Hazard detection:
  - HazardStall = valid & EX_MemRead & (EX_Rt!=0) & (EX_Rt==rs | EX_Rt==rt), using the latched fields. It is combinational.
  - ID_Valid = valid & ~HazardStall, so a bubble is inserted into EX while stalled.
  - Flush and HazardStall in the same cycle: Flush wins; the IF/ID register becomes a NOP. A NOP has rs=rt=0, so the stall drops on the next cycle.
- Sign extension: ID_ImmExt = {{16{instr[15]}}, instr[15:0]}.
- Stall lasts exactly 1 cycle per load-use pair, because the load leaves EX the next cycle.

Optional Feature:
- Macro: ID_WRITE_BYPASS_EN.
- Defined:
  - If WB_RegWrite=1, WB_WriteReg!=0 and WB_WriteReg equals rs (or rt), the corresponding ID_ReadData output returns WB_WriteData in the same cycle.
  - This gives internal write-through forwarding.
- Undefined:
  - Reads return the pre-write array contents in that cycle.
  - The new value appears the cycle after the write edge.
  - Forwarding for this case is then the hazard/forwarding unit's responsibility.

Decomposition:
- Shared package `cpu_defs`:
  - Field bit-positions (OPCODE_MSB/LSB, RS/RT/RD/SHAMT/FUNCT ranges).
  - Constants NOP_INSTR=32'h0, REG_ZERO=5'd0, OP_LW=6'b100011.
- One sub-module: `register_file` (two async read ports, one sync write port, reset-clear, optional bypass under the macro).
- IF/ID register, decode and hazard logic stay in id_stage.

Test Plan:
1. Reset held 2 cycles with IF_Instruction=32'h8C220004 -> ID_Valid=0, ID_* all 0, HazardStall=0. First cycle after release -> ID_Opcode=6'h23, ID_Rs=1, ID_Rt=2, ID_ImmExt=32'h4, ID_Valid=1.
2. WB writes 32'hDEADBEEF to $5, then IF_Instruction=32'h00A53020 (add $6,$5,$5) -> ID_ReadData1=ID_ReadData2=32'hDEADBEEF. A WB write to $0 of 32'h1234 leaves a later $0 read =0.
3. Load-use: EX_MemRead=1, EX_Rt=5 while IF/ID holds rs=5 -> HazardStall=1, ID_Valid=0, IF/ID unchanged for 1 cycle. Next cycle, with EX_MemRead=0 -> HazardStall=0, ID_Valid=1 with the same instruction.
4. Flush asserted together with HazardStall -> next cycle IF/ID=NOP, ID_Valid=0, HazardStall=0.
5. Same-cycle WB write of 32'h00000077 to $7 while decoding rs=7:
   - With ID_WRITE_BYPASS_EN: ID_ReadData1=32'h77 that cycle.
   - Without it: ID_ReadData1 = old value, and 32'h77 the next cycle.
6. Immediate 16'h8001 -> ID_ImmExt=32'hFFFF8001. Reset asserted mid-stream with a pending stall -> all outputs 0 the next cycle.
